// File: rtl/trigger_formatter_s_axi_regs.sv
// AXI4-Lite register file for the trigger_formatter S00_AXI port: four 32-bit registers plus per-register write pulses.
// Define TRIGGER_FORMATTER_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module trigger_formatter_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [127:0]                    regs_out,
  output logic [3:0]                      wr_pulse
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int AW_EXT = (C_S_AXI_ADDR_WIDTH < 4) ? 4 : C_S_AXI_ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic logic addr_in_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    return ((AW_EXT'(a)) >> 4) == '0;
  endfunction

  function automatic logic [1:0] addr_index(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    return 2'((AW_EXT'(a)) >> 2);
  endfunction

  function automatic logic [1:0] oor_resp();
`ifdef TRIGGER_FORMATTER_SLVERR_EN
    return RESP_SLVERR;
`else
    return RESP_OKAY;
`endif
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [STRB_W-1:0] strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic [0:0]                    w_state;
  logic [0:0]                    r_state;
  logic                          aw_latched;
  logic                          w_latched;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]                   w_data_q;
  logic [STRB_W-1:0]             w_strb_q;
  logic [3:0][31:0]              regs_q;

  logic                          aw_hs, w_hs, ar_hs;
  logic                          aw_have, w_have, commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]                   wr_data;
  logic [STRB_W-1:0]             wr_strb;
  logic                          wr_ok;
  logic [1:0]                    wr_idx;
  logic                          rd_ok;
  logic [1:0]                    rd_idx;
  logic                          unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign aw_have = aw_latched | aw_hs;
  assign w_have  = w_latched | w_hs;
  assign commit  = (w_state == W_IDLE) & aw_have & w_have;

  // A channel that handshakes on the commit edge is used directly, bypassing its latch.
  assign wr_addr = aw_latched ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_latched ? w_data_q : S_AXI_WDATA[31:0];
  assign wr_strb = w_latched ? w_strb_q : S_AXI_WSTRB;
  assign wr_ok   = addr_in_range(wr_addr);
  assign wr_idx  = addr_index(wr_addr);
  assign rd_ok   = addr_in_range(S_AXI_ARADDR);
  assign rd_idx  = addr_index(S_AXI_ARADDR);

  assign regs_out = regs_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      aw_latched    <= 1'b0;
      w_latched     <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      regs_q        <= '0;
      wr_pulse      <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            if (wr_ok) begin
              regs_q[wr_idx] <= apply_strb(regs_q[wr_idx], wr_data, wr_strb);
              wr_pulse       <= 4'b0001 << wr_idx;
            end
            S_AXI_BRESP   <= wr_ok ? RESP_OKAY : oor_resp();
            S_AXI_BVALID  <= 1'b1;
            aw_latched    <= 1'b0;
            w_latched     <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            w_state       <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_latched <= 1'b1;
              aw_addr_q  <= S_AXI_AWADDR;
            end
            if (w_hs) begin
              w_latched <= 1'b1;
              w_data_q  <= S_AXI_WDATA[31:0];
              w_strb_q  <= S_AXI_WSTRB;
            end
            S_AXI_AWREADY <= ~aw_have;
            S_AXI_WREADY  <= ~w_have;
          end
        end
        default: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read channel: RDATA is captured from the pre-write register value on the AR edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            S_AXI_RDATA   <= rd_ok ? C_S_AXI_DATA_WIDTH'(regs_q[rd_idx]) : '0;
            S_AXI_RRESP   <= rd_ok ? RESP_OKAY : oor_resp();
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_formatter_s_axi_regs.sv
// Directed bench for trigger_formatter_s_axi_regs with scoreboarded read/write responses.
module tb_trigger_formatter_s_axi_regs;

  localparam logic [1:0] OKAY = 2'b00;
`ifdef TRIGGER_FORMATTER_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [5:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [5:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] regs_out;
  logic [3:0]   wr_pulse;

  int total = 0;
  int passed = 0;
  logic [3:0][31:0] model = '0;
  logic [33:0] rq[$];
  logic [5:0]  bq[$];

  always #5 clk = ~clk;

  trigger_formatter_s_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic in_rng, aw_done, w_done, aw_rdy, w_rdy, got;
    logic [1:0] idx;
    logic [5:0] exp_b;
    in_rng = (addr < 6'h10);
    idx = addr[3:2];
    bq.push_back({in_rng ? OKAY : OOR_RESP, in_rng ? (4'b0001 << idx) : 4'b0000});
    if (in_rng) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
      aw_rdy = awready & awvalid;
      w_rdy  = wready & wvalid;
      tick();
      if (aw_rdy) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_rdy)  begin wvalid = 1'b0;  w_done = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bvalid) got = 1'b1;
      else tick();
    end
    check("bvalid_seen", got, 1'b1);
    if (got) begin
      exp_b = bq.pop_front();
      check("bresp", bresp, exp_b[5:4]);
      check("wr_pulse", wr_pulse, exp_b[3:0]);
      tick();
      check("wr_pulse_clear", {bvalid, wr_pulse}, 5'b0);
    end
    bready = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] addr);
    logic in_rng, done, ar_rdy, got;
    logic [33:0] exp_r;
    in_rng = (addr < 6'h10);
    rq.push_back({in_rng ? OKAY : OOR_RESP, in_rng ? model[addr[3:2]] : 32'h0});
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      ar_rdy = arready;
      tick();
      if (ar_rdy) begin arvalid = 1'b0; done = 1'b1; end
    end
    arvalid = 1'b0;
    check("rd_handshake", done, 1'b1);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (rvalid) got = 1'b1;
      else tick();
    end
    check("rvalid_seen", got, 1'b1);
    if (got) begin
      exp_r = rq.pop_front();
      check("rdata", rdata, exp_r[31:0]);
      check("rresp", rresp, exp_r[33:32]);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check("rvalid_clear", rvalid, 1'b0);
    end
  endtask

  logic [127:0] saved;

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check("reset_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp, wr_pulse}, 15'b0);
    check("reset_regs", regs_out, 128'h0);
    check("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", {awready, wready, arready}, 3'b111);

    // Sequential writes then reads of all four registers.
    bus_write(6'h0, 32'h1, 4'hF);
    bus_write(6'h4, 32'h2, 4'hF);
    bus_write(6'h8, 32'h3, 4'hF);
    bus_write(6'hC, 32'h4, 4'hF);
    check("regs_out_seq", regs_out, 128'h00000004_00000003_00000002_00000001);
    bus_read(6'h0);
    bus_read(6'h4);
    bus_read(6'h8);
    bus_read(6'hC);

    // W arrives three cycles ahead of AW.
    bus_write(6'h8, 32'h0, 4'hF);
    awaddr = 6'h8; wdata = 32'hDEADBEEF; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b0;
    check("w_first_wready", wready, 1'b1);
    tick();
    wvalid = 1'b0;
    check("w_latched_state", {wready, awready, bvalid}, 3'b010);
    tick();
    tick();
    check("w_wait_nobvalid", bvalid, 1'b0);
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("aw_edge_bvalid", bvalid, 1'b1);
    check("aw_edge_pulse", wr_pulse, 4'b0100);
    check("reg2_strobed", regs_out[95:64], 32'h00AD00EF);
    model[2] = 32'h00AD00EF;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("w_first_bclear", bvalid, 1'b0);

    // BREADY held low for ten cycles while a second write waits.
    awaddr = 6'h0; wdata = 32'h0000A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    model[0] = 32'h0000A5A5;
    awaddr = 6'h4; wdata = 32'h00000077;
    check("stall_commit", {bvalid, regs_out[31:0]}, {1'b1, 32'h0000A5A5});
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", {bvalid, bresp, awready, wready, wr_pulse}, {1'b1, OKAY, 2'b00, 4'b0000});
      check("stall_reg1", regs_out[63:32], model[1]);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("stall_release", bvalid, 1'b0);
    tick();
    check("ready_after_bready", {awready, wready}, 2'b11);
    bus_write(6'hC, 32'h00000077, 4'hF);

    // Concurrent write and read of register 1.
    awaddr = 6'h4; wdata = 32'h55; wstrb = 4'hF; araddr = 6'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b0;
    check("concurrent_ready", {awready, wready, arready}, 3'b111);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("concurrent_rdata_old", {rvalid, rdata}, {1'b1, 32'h2});
    check("concurrent_write", {bvalid, regs_out[63:32]}, {1'b1, 32'h55});
    model[1] = 32'h55;
    rready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    check("concurrent_clear", {rvalid, bvalid}, 2'b00);
    bus_read(6'h4);

    // Zero strobe write and unaligned read.
    bus_write(6'hC, 32'hFFFFFFFF, 4'h0);
    check("strb0_unchanged", regs_out[127:96], 32'h00000077);
    bus_read(6'hD);

    // Out-of-range accesses.
    saved = regs_out;
    bus_write(6'h20, 32'h12345678, 4'hF);
    check("oor_regs_unchanged", regs_out, saved);
    bus_read(6'h20);
    bus_write(6'h3C, 32'hCAFEF00D, 4'hF);
    check("oor_regs_unchanged2", regs_out, saved);
    bus_read(6'h3F);

    // Asynchronous reset with a read response pending.
    araddr = 6'h0; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    check("pre_reset_rvalid", rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {rvalid, bvalid, arready, awready, wready, wr_pulse}, 9'b0);
    check("async_reset_regs", regs_out, 128'h0);
    model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_rerelease", {awready, wready, arready}, 3'b111);
    bus_read(6'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
